// File: rtl/sram_dp_param.sv
// Simple-dual-port result SRAM with byte enables and a sequential clear sweep.
// Optional macro SRAM_RD_FWD_EN: same-address read/write returns the post-write word.
module sram_dp_param #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = 7
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Clr,
  input  logic                Wr_En,
  input  logic [ADDR_W-1:0]   Wr_Addr,
  input  logic [DATA_W/8-1:0] Wr_Be,
  input  logic [DATA_W-1:0]   Data_In,
  input  logic                Rd_En,
  input  logic [ADDR_W-1:0]   Rd_Addr,
  output logic [DATA_W-1:0]   Data_Out,
  output logic                Rd_Valid,
  output logic                Addr_Err,
  output logic                Busy,
  output logic                Clr_Done
);

  localparam int unsigned       NumBytes = DATA_W / 8;
  localparam logic [ADDR_W:0]   DepthW   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastPtr  = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                rd_valid_q, rd_valid_d;
  logic                addr_err_q, addr_err_d;
  logic                clr_done_q, clr_done_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                wr_ok, rd_ok;
  logic [ADDR_W-1:0]   wr_idx, rd_idx;
  logic [DATA_W-1:0]   be_mask;
  logic [DATA_W-1:0]   rd_word, rd_fwd;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_idx;
  logic [NumBytes-1:0] mem_be;
  logic [DATA_W-1:0]   mem_wdata;

  // Out-of-range addresses are clamped to 0 so the array is never indexed past DEPTH.
  always_comb begin
    wr_ok  = {1'b0, Wr_Addr} < DepthW;
    rd_ok  = {1'b0, Rd_Addr} < DepthW;
    wr_idx = wr_ok ? Wr_Addr : '0;
    rd_idx = rd_ok ? Rd_Addr : '0;
    for (int i = 0; i < NumBytes; i++) begin
      be_mask[8*i +: 8] = {8{Wr_Be[i]}};
    end
    rd_word = mem_q[rd_idx];
  end

`ifdef SRAM_RD_FWD_EN
  logic collide;
  always_comb begin
    collide = Wr_En && wr_ok && (Wr_Addr == Rd_Addr);
    rd_fwd  = collide ? ((Data_In & be_mask) | (rd_word & ~be_mask)) : rd_word;
  end
`else
  always_comb begin
    rd_fwd = rd_word;
  end
`endif

  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = wr_idx;
    mem_be    = Wr_Be;
    mem_wdata = Data_In;
    if (state_q == StClear) begin
      mem_we    = 1'b1;
      mem_idx   = ptr_q;
      mem_be    = '1;
      mem_wdata = '0;
    end else begin
      mem_we = Wr_En && wr_ok && (|Wr_Be);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst && mem_we) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (mem_be[i]) begin
          mem_q[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    data_out_d = '0;
    rd_valid_d = 1'b0;
    addr_err_d = 1'b0;
    clr_done_d = 1'b0;
    unique case (state_q)
      StClear: begin
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == LastPtr) begin
          state_d    = StIdle;
          ptr_d      = '0;
          clr_done_d = 1'b1;
        end
      end
      StIdle: begin
        rd_valid_d = Rd_En;
        data_out_d = (Rd_En && rd_ok) ? rd_fwd : '0;
        addr_err_d = (Wr_En && !wr_ok) || (Rd_En && !rd_ok);
        // Any access in this cycle still completes; the sweep starts next cycle.
        if (Clr) begin
          state_d = StClear;
          ptr_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q    <= StClear;
      ptr_q      <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      addr_err_q <= addr_err_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign Data_Out = data_out_q;
  assign Rd_Valid = rd_valid_q;
  assign Addr_Err = addr_err_q;
  assign Clr_Done = clr_done_q;
  assign Busy     = (state_q == StClear);

endmodule

// File: tb/tb_sram_dp_param.sv
// Directed bench for sram_dp_param: a DEPTH=128 instance plus a DEPTH=100 instance on shared inputs.
module tb_sram_dp_param;

  logic        Clk = 1'b0;
  logic        Rst, Clr, Wr_En, Rd_En;
  logic [6:0]  Wr_Addr, Rd_Addr;
  logic [3:0]  Wr_Be;
  logic [31:0] Data_In;

  logic [31:0] Data_Out, d100_data_out;
  logic        Rd_Valid, Addr_Err, Busy, Clr_Done;
  logic        d100_rd_valid, d100_addr_err, d100_busy, d100_clr_done;

  int checks = 0;
  int errors = 0;
  int cnt;

  always #5 Clk = ~Clk;

  sram_dp_param #(.DATA_W(32), .DEPTH(128), .ADDR_W(7)) u_dut (
    .Clk(Clk), .Rst(Rst), .Clr(Clr), .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Be(Wr_Be),
    .Data_In(Data_In), .Rd_En(Rd_En), .Rd_Addr(Rd_Addr), .Data_Out(Data_Out),
    .Rd_Valid(Rd_Valid), .Addr_Err(Addr_Err), .Busy(Busy), .Clr_Done(Clr_Done)
  );

  sram_dp_param #(.DATA_W(32), .DEPTH(100), .ADDR_W(7)) u_dut100 (
    .Clk(Clk), .Rst(Rst), .Clr(Clr), .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Be(Wr_Be),
    .Data_In(Data_In), .Rd_En(Rd_En), .Rd_Addr(Rd_Addr), .Data_Out(d100_data_out),
    .Rd_Valid(d100_rd_valid), .Addr_Err(d100_addr_err), .Busy(d100_busy),
    .Clr_Done(d100_clr_done)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    Clr = 0; Wr_En = 0; Rd_En = 0; Wr_Addr = '0; Rd_Addr = '0; Wr_Be = '0; Data_In = '0;
  endtask

  task automatic write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] be);
    Wr_En = 1; Wr_Addr = a; Data_In = d; Wr_Be = be;
    tick();
    Wr_En = 0;
  endtask

  task automatic read(input logic [6:0] a);
    Rd_En = 1; Rd_Addr = a;
    tick();
    Rd_En = 0;
  endtask

  task automatic count_busy();
    cnt = 0;
    while (Busy && cnt < 300) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    Rst = 0;
    idle_inputs();
    tick();
    tick();
    check("reset_data_out", Data_Out, 32'h0);
    check("reset_rd_valid", {31'h0, Rd_Valid}, 32'h0);
    check("reset_addr_err", {31'h0, Addr_Err}, 32'h0);
    check("reset_clr_done", {31'h0, Clr_Done}, 32'h0);
    check("reset_busy", {31'h0, Busy}, 32'h1);

    // Initial sweep after reset release.
    Rst = 1;
    count_busy();
    check("init_busy_cycles", cnt, 32'd128);
    check("init_clr_done", {31'h0, Clr_Done}, 32'h1);
    check("d100_idle_after_sweep", {31'h0, d100_busy}, 32'h0);
    tick();
    check("init_clr_done_pulse", {31'h0, Clr_Done}, 32'h0);
    read(7'd77);
    check("init_read_valid", {31'h0, Rd_Valid}, 32'h1);
    check("init_read_zero", Data_Out, 32'h0);
    tick();
    check("rd_en_low_valid", {31'h0, Rd_Valid}, 32'h0);

    // Byte-enable merge and Be=0 no-op.
    write(7'd5, 32'hDEADBEEF, 4'hF);
    write(7'd5, 32'h11223344, 4'b0101);
    read(7'd5);
    check("be_merge_valid", {31'h0, Rd_Valid}, 32'h1);
    check("be_merge_data", Data_Out, 32'hDE22BE44);
    tick();
    check("rd_en_low_data", Data_Out, 32'h0);
    write(7'd5, 32'hFFFFFFFF, 4'h0);
    read(7'd5);
    check("be_zero_noop", Data_Out, 32'hDE22BE44);

    // Same-address collision.
    write(7'd9, 32'hAAAAAAAA, 4'hF);
    Wr_En = 1; Wr_Addr = 7'd9; Data_In = 32'h55555555; Wr_Be = 4'hF;
    Rd_En = 1; Rd_Addr = 7'd9;
    tick();
    Wr_En = 0; Rd_En = 0;
`ifdef SRAM_RD_FWD_EN
    check("collide_read", Data_Out, 32'h55555555);
`else
    check("collide_read", Data_Out, 32'hAAAAAAAA);
`endif
    read(7'd9);
    check("collide_mem", Data_Out, 32'h55555555);

    // Different-address simultaneous access, then back-to-back reads.
    Wr_En = 1; Wr_Addr = 7'd10; Data_In = 32'h12345678; Wr_Be = 4'hF;
    Rd_En = 1; Rd_Addr = 7'd5;
    tick();
    Wr_En = 0;
    check("dual_read", Data_Out, 32'hDE22BE44);
    Rd_Addr = 7'd10;
    tick();
    check("b2b_read0", Data_Out, 32'h12345678);
    Rd_Addr = 7'd9;
    tick();
    Rd_En = 0;
    check("b2b_read1", Data_Out, 32'h55555555);
    check("b2b_valid", {31'h0, Rd_Valid}, 32'h1);

    // Out-of-range on the DEPTH=100 instance.
    write(7'd20, 32'hCAFEF00D, 4'hF);
    write(7'd120, 32'hBAD0BAD0, 4'hF);
    check("oor_wr_err", {31'h0, d100_addr_err}, 32'h1);
    check("inrange_wr_no_err", {31'h0, Addr_Err}, 32'h0);
    read(7'd120);
    check("oor_rd_err", {31'h0, d100_addr_err}, 32'h1);
    check("oor_rd_valid", {31'h0, d100_rd_valid}, 32'h1);
    check("oor_rd_data", d100_data_out, 32'h0);
    read(7'd20);
    check("no_alias_data", d100_data_out, 32'hCAFEF00D);
    check("no_alias_err", {31'h0, d100_addr_err}, 32'h0);

    // Clear sweep with Clr/Rd_En during busy.
    for (int i = 0; i < 4; i++) write(7'(i), 32'hA0A0A0A0 + 32'(i), 4'hF);
    read(7'd3);
    check("fill_addr3", Data_Out, 32'hA0A0A0A3);
    Clr = 1;
    tick();
    Clr = 0;
    cnt = 0;
    while (Busy && cnt < 300) begin
      cnt++;
      Clr = (cnt == 2);
      Rd_En = (cnt == 2);
      Rd_Addr = 7'd0;
      tick();
      if (cnt == 2) check("busy_rd_valid", {31'h0, Rd_Valid}, 32'h0);
    end
    Clr = 0; Rd_En = 0;
    check("clr_busy_cycles", cnt, 32'd128);
    check("clr_done", {31'h0, Clr_Done}, 32'h1);
    Rd_En = 1;
    for (int i = 0; i < 4; i++) begin
      Rd_Addr = 7'(i);
      tick();
      check($sformatf("cleared_addr%0d", i), Data_Out, 32'h0);
    end
    Rd_En = 0;

    // Reset in the middle of a sweep restarts it.
    write(7'd5, 32'h0BADCAFE, 4'hF);
    Clr = 1;
    tick();
    Clr = 0;
    for (int i = 0; i < 59; i++) tick();
    Rst = 0;
    tick();
    Rst = 1;
    check("midsweep_rst_busy", {31'h0, Busy}, 32'h1);
    count_busy();
    check("restart_busy_cycles", cnt, 32'd128);
    check("restart_clr_done", {31'h0, Clr_Done}, 32'h1);
    read(7'd5);
    check("restart_cleared", Data_Out, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
